rr_request_encoder: RTL and testbench

- Round-robin request encoder for the arbiter: the request-side counterpart of the grant decoder.
- Samples an 8-bit request vector and selects one requester fairly. It produces a registered 3-bit grant index plus a valid flag; the grant decoder expands that index back to one-hot grants.
- Holds each grant until the requester releases it, `done_i` pulses, or a hold timeout expires. Then rotates priority past the served requester.

---
 rtl/rr_request_encoder.sv | 99 +++++++++
 tb/tb_rr_request_encoder.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/rr_request_encoder.sv
// Round-robin request encoder: picks one requester fairly and holds its grant
// until release, done pulse or hold timeout, then rotates priority past it.
//
// state   | meaning
// IDLE    | no grant; select the next requester from ptr when enabled
// GRANT   | grant active; watch for enable drop, done, request drop, timeout
// RELEASE | one forced gap cycle with no grant before returning to IDLE
module rr_request_encoder #(
    parameter int N_REQ    = 8,
    parameter int IDX_W    = 3,
    parameter int MAX_HOLD = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic [N_REQ-1:0] req_i,
    input  logic             done_i,
    output logic [IDX_W-1:0] grant_idx_o,
    output logic             grant_valid_o,
    output logic             timeout_o
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_GRANT   = 2'd1;
    localparam logic [1:0] S_RELEASE = 2'd2;

    localparam logic [7:0] HOLD_MAX = 8'(MAX_HOLD);

    logic [1:0]       state;
    logic [IDX_W-1:0] ptr;
    logic [7:0]       cnt;

    logic [IDX_W-1:0] sel;
    logic [IDX_W-1:0] k;
    logic             found;
    logic             rel_other;
    logic             rel_timeout;

    // First set request at or above ptr, wrapping modulo N_REQ.
    always_comb begin
        sel   = '0;
        k     = '0;
        found = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            k = ptr + IDX_W'(i);
            if (!found && req_i[k]) begin
                sel   = k;
                found = 1'b1;
            end
        end
    end

    // Timeout only counts as the cause when no higher-priority release applies.
    always_comb begin
        rel_other   = !enable || done_i || !req_i[grant_idx_o];
        rel_timeout = !rel_other && (cnt == HOLD_MAX);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            ptr           <= '0;
            cnt           <= '0;
            grant_idx_o   <= '0;
            grant_valid_o <= 1'b0;
            timeout_o     <= 1'b0;
        end else begin
            timeout_o <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (enable && found) begin
                        grant_idx_o   <= sel;
                        grant_valid_o <= 1'b1;
                        cnt           <= 8'd1;
                        state         <= S_GRANT;
                    end
                end
                S_GRANT: begin
                    if (rel_other || rel_timeout) begin
                        grant_valid_o <= 1'b0;
                        timeout_o     <= rel_timeout;
                        ptr           <= grant_idx_o + IDX_W'(1);
                        state         <= S_RELEASE;
                    end else if (cnt != HOLD_MAX) begin
                        cnt <= cnt + 8'd1;
                    end
                end
                S_RELEASE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state         <= S_IDLE;
                    grant_valid_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rr_request_encoder.sv
// Directed bench for rr_request_encoder; inputs driven and outputs sampled on
// the falling clock edge.
module tb_rr_request_encoder;

    logic       clk;
    logic       rst_n;
    logic       enable;
    logic [7:0] req_i;
    logic       done_i;
    logic [2:0] grant_idx_o;
    logic       grant_valid_o;
    logic       timeout_o;

    int vectors = 0;
    int errors  = 0;

    rr_request_encoder #(.N_REQ(8), .IDX_W(3), .MAX_HOLD(16)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .req_i        (req_i),
        .done_i       (done_i),
        .grant_idx_o  (grant_idx_o),
        .grant_valid_o(grant_valid_o),
        .timeout_o    (timeout_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk_valid(input string name, input logic exp);
        vectors++;
        if (grant_valid_o !== exp) begin
            errors++;
            $display("FAIL %s: grant_valid_o=%b expected %b", name, grant_valid_o, exp);
        end
    endtask

    task automatic chk_grant(input string name, input logic [2:0] exp);
        vectors++;
        if (grant_valid_o !== 1'b1 || grant_idx_o !== exp) begin
            errors++;
            $display("FAIL %s: valid=%b idx=%0d expected valid=1 idx=%0d",
                     name, grant_valid_o, grant_idx_o, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n  = 1'b0;
        enable = 1'b0;
        req_i  = '0;
        done_i = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        vectors++;
        if (grant_valid_o !== 1'b0 || grant_idx_o !== 3'd0 || timeout_o !== 1'b0) begin
            errors++;
            $display("FAIL reset: valid=%b idx=%0d timeout=%b expected 0 0 0",
                     grant_valid_o, grant_idx_o, timeout_o);
        end
    endtask

    // Leaves ptr=3 with the DUT in RELEASE.
    task automatic test_single_grant();
        enable = 1'b1;
        req_i  = 8'b0000_0100;
        step();
        chk_grant("single_grant", 3'd2);
        req_i = '0;
        step();
        chk_valid("single_release", 1'b0);
    endtask

    task automatic test_rotation();
        logic [2:0] order [4];
        order = '{3'd7, 3'd0, 3'd2, 3'd7};
        req_i = 8'b1000_0101;
        step();
        chk_valid("rot_gap_idle", 1'b0);
        for (int g = 0; g < 4; g++) begin
            step();
            chk_grant($sformatf("rot_grant%0d", g), order[g]);
            done_i = 1'b1;
            if (g == 3) req_i = 8'b0000_0001;
            step();
            done_i = 1'b0;
            chk_valid($sformatf("rot_gap_a%0d", g), 1'b0);
            step();
            chk_valid($sformatf("rot_gap_b%0d", g), 1'b0);
        end
    endtask

    // Entered with ptr=0, DUT in IDLE, req_i=1.
    task automatic test_timeout();
        int hi = 0;
        int gap = 0;
        int pulses = 0;
        int n = 0;
        step();
        chk_grant("to_first_grant", 3'd0);
        while (grant_valid_o === 1'b1 && n < 40) begin
            if (timeout_o === 1'b1) pulses++;
            hi++;
            n++;
            step();
        end
        vectors++;
        if (hi != 16) begin
            errors++;
            $display("FAIL to_hold_len: held %0d cycles expected 16", hi);
        end
        vectors++;
        if (timeout_o !== 1'b1) begin
            errors++;
            $display("FAIL to_pulse_edge: timeout_o=%b expected 1", timeout_o);
        end
        n = 0;
        while (grant_valid_o !== 1'b1 && n < 10) begin
            if (timeout_o === 1'b1) pulses++;
            gap++;
            n++;
            step();
        end
        vectors++;
        if (gap != 2) begin
            errors++;
            $display("FAIL to_gap: gap %0d cycles expected 2", gap);
        end
        vectors++;
        if (pulses != 1) begin
            errors++;
            $display("FAIL to_pulse_count: %0d pulses expected 1", pulses);
        end
        chk_grant("to_regrant", 3'd0);
    endtask

    task automatic test_enable_drop();
        do_reset();
        enable = 1'b1;
        req_i  = 8'h20;
        step();
        chk_grant("en_grant5", 3'd5);
        enable = 1'b0;
        req_i  = 8'hFF;
        step();
        vectors++;
        if (grant_valid_o !== 1'b0 || timeout_o !== 1'b0) begin
            errors++;
            $display("FAIL en_release: valid=%b timeout=%b expected 0 0",
                     grant_valid_o, timeout_o);
        end
        for (int i = 0; i < 5; i++) begin
            step();
            chk_valid($sformatf("en_blocked%0d", i), 1'b0);
        end
        enable = 1'b1;
        step();
        chk_grant("en_resume6", 3'd6);
    endtask

    task automatic test_async_reset();
        do_reset();
        enable = 1'b1;
        req_i  = 8'h10;
        step();
        chk_grant("ar_grant4", 3'd4);
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if (grant_valid_o !== 1'b0 || grant_idx_o !== 3'd0) begin
            errors++;
            $display("FAIL ar_immediate: valid=%b idx=%0d expected 0 0",
                     grant_valid_o, grant_idx_o);
        end
        @(negedge clk);
        rst_n = 1'b1;
        req_i = 8'h30;
        step();
        chk_grant("ar_regrant4", 3'd4);
    endtask

    task automatic test_done_and_drop();
        do_reset();
        enable = 1'b1;
        req_i  = 8'h40;
        step();
        chk_grant("dd_grant6", 3'd6);
        done_i = 1'b1;
        req_i  = 8'h00;
        step();
        done_i = 1'b0;
        chk_valid("dd_release", 1'b0);
        req_i = 8'b1100_0000;
        step();
        chk_valid("dd_gap", 1'b0);
        step();
        chk_grant("dd_grant7", 3'd7);
    endtask

    initial begin
        rst_n  = 1'b0;
        enable = 1'b0;
        req_i  = '0;
        done_i = 1'b0;
        test_reset();
        test_single_grant();
        test_rotation();
        test_timeout();
        test_enable_drop();
        test_async_reset();
        test_done_and_drop();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
